// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, oversampled mid-bit sampling, 8N1-style framing.
// Emits a one-cycle valid per good byte and a one-cycle frame_err per bad stop bit.
module uart_rx #(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int SAMPLE_DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

    state_t               state, state_n;
    logic [1:0]           sync_q;
    logic                 rxs;
    logic [TW-1:0]        tick_cnt;
    logic [SW-1:0]        samp_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] sh;
    logic                 tick;
    logic                 mid_hit;
    logic                 end_hit;

    assign rxs     = sync_q[1];
    assign tick    = (tick_cnt == TICK_LAST);
    assign mid_hit = tick && (samp_cnt == SAMP_MID);
    assign end_hit = tick && (samp_cnt == SAMP_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (!rxs) state_n = START;
            START:   if (mid_hit) state_n = rxs ? IDLE : DATA;
            DATA:    if (end_hit && bit_cnt == BIT_LAST) state_n = STOP;
            STOP:    if (end_hit) state_n = rxs ? IDLE : RECOVER;
            RECOVER: if (rxs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: synchronizer, counters, shift register and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            tick_cnt  <= '0;
            samp_cnt  <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rxd};
            valid     <= 1'b0;
            frame_err <= 1'b0;

            if (state == IDLE || state == RECOVER || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + TW'(1);

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        samp_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                START: begin
                    if (mid_hit)   samp_cnt <= '0;
                    else if (tick) samp_cnt <= samp_cnt + SW'(1);
                end
                DATA: begin
                    if (end_hit) begin
                        samp_cnt <= '0;
                        sh       <= {rxs, sh[DATA_BITS-1:1]};
                        bit_cnt  <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
                    end else if (tick) begin
                        samp_cnt <= samp_cnt + SW'(1);
                    end
                end
                STOP: begin
                    if (end_hit) begin
                        samp_cnt <= '0;
                        if (rxs) begin
                            data  <= sh;
                            valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (tick) begin
                        samp_cnt <= samp_cnt + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a scoreboard queue and an independent pulse monitor.
// Runs at SAMPLE_DIV=27 (432 cycles/bit, half-bit 216) to keep the run short.
module tb_uart_rx;
    localparam int BIT  = 432;
    localparam int HALF = 216;
    localparam int LAT  = 3 + HALF + 9 * BIT;   // pin fall to valid-high cycle

    typedef struct {
        bit         err;
        logic [7:0] d;
        time        t0;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    exp_t sbq[$];
    time  vtimes[$];
    exp_t em;
    int   total = 0;
    int   bad   = 0;

    uart_rx #(.CLOCK_RATE(50000000), .BAUD_RATE(115200), .OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .data(data),
        .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic chk_rng(input string name, input int got, input int lo, input int hi);
        total++;
        if (got < lo || got > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input bit err, input logic [7:0] d);
        sbq.push_back('{err, d, $time});
    endtask

    task automatic send(input logic [7:0] b, input int per, input logic stop);
        rxd = 1'b0;
        wait_cyc(per);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cyc(per);
        end
        rxd = stop;
        wait_cyc(per);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid && frame_err) chk("strobe exclusive", 1, 0);
        if (valid || frame_err) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected strobe: valid=%0b frame_err=%0b data=%0h", valid, frame_err, data);
            end else begin
                em = sbq.pop_front();
                chk("strobe kind", int'(frame_err), int'(em.err));
                chk("data", int'(data), int'(em.d));
                chk_rng("latency", int'(($time - em.t0) / 10), LAT - 2, LAT + 2);
            end
            if (valid) vtimes.push_back($time);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        wait_cyc(3);
        chk("reset data", int'(data), 0);
        chk("reset valid", int'(valid), 0);
        chk("reset frame_err", int'(frame_err), 0);
        chk("reset busy", int'(busy), 0);
        rst = 1'b0;
        wait_cyc(5);

        // single frame
        expect_ev(1'b0, 8'h55);
        send(8'h55, BIT, 1'b1);
        wait_cyc(BIT);

        // back-to-back, zero idle gap
        vtimes.delete();
        expect_ev(1'b0, 8'hA5); send(8'hA5, BIT, 1'b1);
        expect_ev(1'b0, 8'h00); send(8'h00, BIT, 1'b1);
        expect_ev(1'b0, 8'hFF); send(8'hFF, BIT, 1'b1);
        wait_cyc(BIT);
        chk("b2b count", vtimes.size(), 3);
        if (vtimes.size() == 3) begin
            chk_rng("b2b gap1", int'((vtimes[1] - vtimes[0]) / 10), 10 * BIT - 2, 10 * BIT + 2);
            chk_rng("b2b gap2", int'((vtimes[2] - vtimes[1]) / 10), 10 * BIT - 2, 10 * BIT + 2);
        end

        // glitch shorter than half a bit is rejected as a false start
        rxd = 1'b0;
        wait_cyc(10);
        chk("glitch busy", int'(busy), 1);
        wait_cyc(90);
        rxd = 1'b1;
        wait_cyc(140);
        chk("glitch idle", int'(busy), 0);
        wait_cyc(BIT);
        expect_ev(1'b0, 8'h3C);
        send(8'h3C, BIT, 1'b1);
        wait_cyc(BIT);

        // framing error, then break held low
        expect_ev(1'b1, 8'h3C);
        send(8'h81, BIT, 1'b0);
        wait_cyc(3 * BIT);
        chk("break busy", int'(busy), 1);
        rxd = 1'b1;
        wait_cyc(5);
        chk("recover idle", int'(busy), 0);
        chk("data held", int'(data), 8'h3C);
        wait_cyc(BIT);

        // reset in the middle of bit 4 of 0xC3; the link idles with it
        rxd = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 4; i++) begin
            rxd = (8'hC3 >> i) & 1'b1;
            wait_cyc(BIT);
        end
        rxd = 1'b0;
        wait_cyc(HALF);
        rst = 1'b1;
        rxd = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        chk("mid rst data", int'(data), 0);
        chk("mid rst valid", int'(valid), 0);
        chk("mid rst frame_err", int'(frame_err), 0);
        chk("mid rst busy", int'(busy), 0);
        wait_cyc(2 * BIT);
        expect_ev(1'b0, 8'h5A);
        send(8'h5A, BIT, 1'b1);
        wait_cyc(BIT);

        // transmitter at -2% and +2% bit period
        expect_ev(1'b0, 8'h96);
        send(8'h96, 423, 1'b1);
        wait_cyc(2 * BIT);
        expect_ev(1'b0, 8'h96);
        send(8'h96, 441, 1'b1);
        wait_cyc(2 * BIT);

        chk("scoreboard drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
